// File: rtl/cpu31_alu_pkg.sv
// Shared ALU definitions: opcode constants, flag bundle, arbiter state encoding.
// Used by alu, alu_arb_pick and alu_arbiter.
package cpu31_alu_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ALUC_W  = 4;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned SHAMT_W = 5;

    localparam logic [ALUC_W-1:0] ALU_ADDU = 4'b0000;
    localparam logic [ALUC_W-1:0] ALU_SUBU = 4'b0001;
    localparam logic [ALUC_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [ALUC_W-1:0] ALU_SUB  = 4'b0011;
    localparam logic [ALUC_W-1:0] ALU_AND  = 4'b0100;
    localparam logic [ALUC_W-1:0] ALU_OR   = 4'b0101;
    localparam logic [ALUC_W-1:0] ALU_XOR  = 4'b0110;
    localparam logic [ALUC_W-1:0] ALU_NOR  = 4'b0111;
    localparam logic [ALUC_W-1:0] ALU_LUI  = 4'b1000;
    localparam logic [ALUC_W-1:0] ALU_LUI1 = 4'b1001;
    localparam logic [ALUC_W-1:0] ALU_SLTU = 4'b1010;
    localparam logic [ALUC_W-1:0] ALU_SLT  = 4'b1011;
    localparam logic [ALUC_W-1:0] ALU_SRA  = 4'b1100;
    localparam logic [ALUC_W-1:0] ALU_SRL  = 4'b1101;
    localparam logic [ALUC_W-1:0] ALU_SLL  = 4'b1110;
    localparam logic [ALUC_W-1:0] ALU_SLL1 = 4'b1111;

    typedef struct packed {
        logic zero;
        logic carry;
        logic negative;
        logic overflow;
    } alu_flags_t;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_RESP = 1'b1
    } arb_state_t;

    // Carry is only meaningful for unsigned arithmetic, SLTU and the shifts.
    function automatic logic carry_kept(input logic [ALUC_W-1:0] aluc);
        return (aluc == ALU_ADDU) || (aluc == ALU_SUBU) || (aluc == ALU_SLTU) ||
               (aluc == ALU_SRA)  || (aluc == ALU_SRL)  ||
               (aluc == ALU_SLL)  || (aluc == ALU_SLL1);
    endfunction

    // Overflow is only meaningful for signed add/subtract.
    function automatic logic ovf_kept(input logic [ALUC_W-1:0] aluc);
        return (aluc == ALU_ADD) || (aluc == ALU_SUB);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU with zero/carry/negative/overflow flags.
// Shift opcodes shift b by a[4:0]; carry is the last bit shifted out.
module alu
    import cpu31_alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [ALUC_W-1:0] aluc,
    output logic [DATA_W-1:0] r,
    output logic              zero,
    output logic              carry,
    output logic              negative,
    output logic              overflow
);

    logic [DATA_W:0]    w_sum;
    logic [DATA_W:0]    w_diff;
    logic [SHAMT_W-1:0] w_sh;
    logic [SHAMT_W-1:0] w_lsb_idx;
    logic [SHAMT_W-1:0] w_msb_idx;

    assign w_sum     = {1'b0, a} + {1'b0, b};
    assign w_diff    = {1'b0, a} - {1'b0, b};
    assign w_sh      = a[SHAMT_W-1:0];
    assign w_lsb_idx = w_sh - 5'd1;
    assign w_msb_idx = 5'(6'd32 - {1'b0, w_sh});

    always_comb begin
        r        = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (aluc)
            ALU_ADDU: begin
                r     = w_sum[DATA_W-1:0];
                carry = w_sum[DATA_W];
            end
            ALU_SUBU: begin
                r     = w_diff[DATA_W-1:0];
                carry = w_diff[DATA_W];
            end
            ALU_ADD: begin
                r        = w_sum[DATA_W-1:0];
                overflow = (a[DATA_W-1] == b[DATA_W-1]) && (w_sum[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_SUB: begin
                r        = w_diff[DATA_W-1:0];
                overflow = (a[DATA_W-1] != b[DATA_W-1]) && (w_diff[DATA_W-1] != a[DATA_W-1]);
            end
            ALU_AND:            r = a & b;
            ALU_OR:             r = a | b;
            ALU_XOR:            r = a ^ b;
            ALU_NOR:            r = ~(a | b);
            ALU_LUI, ALU_LUI1:  r = {b[15:0], 16'h0000};
            ALU_SLTU: begin
                r     = {31'b0, w_diff[DATA_W]};
                carry = w_diff[DATA_W];
            end
            ALU_SLT:            r = {31'b0, ($signed(a) < $signed(b))};
            ALU_SRA: begin
                r     = 32'($signed(b) >>> w_sh);
                carry = (w_sh != '0) && b[w_lsb_idx];
            end
            ALU_SRL: begin
                r     = b >> w_sh;
                carry = (w_sh != '0) && b[w_lsb_idx];
            end
            ALU_SLL, ALU_SLL1: begin
                r     = b << w_sh;
                carry = (w_sh != '0) && b[w_msb_idx];
            end
            default: r = '0;
        endcase
        zero     = (r == '0);
        negative = r[DATA_W-1];
    end

endmodule

// File: rtl/alu_arb_pick.sv
// Two-way grant selector: one-hot grant to a valid requester, the pointer
// naming which port wins when both are valid.
module alu_arb_pick
    import cpu31_alu_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic               i_pointer,
    output logic [NUM_REQ-1:0] o_grant_c
);

    always_comb begin
        o_grant_c = '0;
        case (i_req_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = i_pointer ? 2'b10 : 2'b01;
            default: o_grant_c = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters time-share one ALU; results held in a one-deep response register.
// ALU_ARBITER_RR_EN selects round-robin grant; otherwise port 0 has fixed priority.
module alu_arbiter
    import cpu31_alu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [DATA_W-1:0]   req_a0,
    input  logic [DATA_W-1:0]   req_b0,
    input  logic [DATA_W-1:0]   req_a1,
    input  logic [DATA_W-1:0]   req_b1,
    input  logic [ALUC_W-1:0]   req_aluc0,
    input  logic [ALUC_W-1:0]   req_aluc1,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [DATA_W-1:0]   rsp_r,
    output logic                rsp_zero,
    output logic                rsp_carry,
    output logic                rsp_negative,
    output logic                rsp_overflow,
    output logic [CNT_W-1:0]    op_count
);

    arb_state_t          r_state;
    logic                r_rsp_valid;
    logic                r_rsp_id;
    logic [DATA_W-1:0]   r_rsp_r;
    alu_flags_t          r_flags;
    logic [CNT_W-1:0]    r_op_count;

    logic                w_ptr;
    logic [NUM_REQ-1:0]  w_grant;
    logic                w_can_accept;
    logic                w_accept;
    logic                w_retire;
    logic                w_sel;
    logic [DATA_W-1:0]   w_a;
    logic [DATA_W-1:0]   w_b;
    logic [ALUC_W-1:0]   w_aluc;
    logic [DATA_W-1:0]   w_alu_r;
    alu_flags_t          w_alu_flags;

`ifdef ALU_ARBITER_RR_EN
    logic r_ptr;

    // Preferred port flips to the port that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 1'b0;
        end else if (w_accept) begin
            r_ptr <= ~w_sel;
        end
    end

    assign w_ptr = r_ptr;
`else
    assign w_ptr = 1'b0;
`endif

    alu_arb_pick u_pick (
        .i_req_valid (req_valid),
        .i_pointer   (w_ptr),
        .o_grant_c   (w_grant)
    );

    // A new operation may enter when the holding register is empty or retiring now.
    assign w_can_accept = (r_state == ARB_IDLE) || rsp_ready;
    assign req_ready    = w_can_accept ? w_grant : '0;
    assign w_accept     = |req_ready;
    assign w_retire     = r_rsp_valid && rsp_ready;
    assign w_sel        = w_grant[1];

    assign w_a    = w_sel ? req_a1    : req_a0;
    assign w_b    = w_sel ? req_b1    : req_b0;
    assign w_aluc = w_sel ? req_aluc1 : req_aluc0;

    alu u_alu (
        .a        (w_a),
        .b        (w_b),
        .aluc     (w_aluc),
        .r        (w_alu_r),
        .zero     (w_alu_flags.zero),
        .carry    (w_alu_flags.carry),
        .negative (w_alu_flags.negative),
        .overflow (w_alu_flags.overflow)
    );

    // Arbiter FSM with the response register and completion counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_r     <= '0;
            r_flags     <= '0;
            r_op_count  <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_accept) begin
                        r_state     <= ARB_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                ARB_RESP: begin
                    if (w_retire && !w_accept) begin
                        r_state     <= ARB_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ARB_IDLE;
                    r_rsp_valid <= 1'b0;
                end
            endcase

            if (w_accept) begin
                r_rsp_id         <= w_sel;
                r_rsp_r          <= w_alu_r;
                r_flags.zero     <= w_alu_flags.zero;
                r_flags.negative <= w_alu_flags.negative;
                r_flags.carry    <= w_alu_flags.carry && carry_kept(w_aluc);
                r_flags.overflow <= w_alu_flags.overflow && ovf_kept(w_aluc);
            end

            if (w_retire) begin
                r_op_count <= r_op_count + CNT_W'(1);
            end
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_r        = r_rsp_r;
    assign rsp_zero     = r_flags.zero;
    assign rsp_carry    = r_flags.carry;
    assign rsp_negative = r_flags.negative;
    assign rsp_overflow = r_flags.overflow;
    assign op_count     = r_op_count;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: grant/ALU reference model feeding a
// result queue, compared against the response register every cycle.
module tb_alu_arbiter;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic        id;
        logic [31:0] r;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [31:0]       a0, b0, a1, b1;
    logic [3:0]        c0, c1;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [31:0]       rsp_r;
    logic              rsp_zero, rsp_carry, rsp_negative, rsp_overflow;
    logic [CNT_W-1:0]  op_count;

    exp_t              exp_q[$];
    int                total;
    int                bad;
    logic              m_valid;
    logic [CNT_W-1:0]  m_count;
`ifdef ALU_ARBITER_RR_EN
    logic              m_ptr;
`endif

    alu_arbiter #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a0       (a0),
        .req_b0       (b0),
        .req_a1       (a1),
        .req_b1       (b1),
        .req_aluc0    (c0),
        .req_aluc1    (c1),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_r        (rsp_r),
        .rsp_zero     (rsp_zero),
        .rsp_carry    (rsp_carry),
        .rsp_negative (rsp_negative),
        .rsp_overflow (rsp_overflow),
        .op_count     (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
        exp_t        e;
        logic [63:0] t;
        longint      sa, sb, ss;
        int          sh;
        e  = '0;
        e.id = id;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(a[4:0]);
        case (op)
            4'd0: begin t = 64'(a) + 64'(b); e.r = t[31:0]; e.c = t[32]; end
            4'd1: begin e.r = a - b; e.c = (a < b); end
            4'd2: begin ss = sa + sb; e.r = 32'(ss); e.v = (ss != longint'($signed(e.r))); end
            4'd3: begin ss = sa - sb; e.r = 32'(ss); e.v = (ss != longint'($signed(e.r))); end
            4'd4: e.r = a & b;
            4'd5: e.r = a | b;
            4'd6: e.r = a ^ b;
            4'd7: e.r = ~(a | b);
            4'd8, 4'd9: e.r = {b[15:0], 16'h0000};
            4'd10: begin e.r = (a < b) ? 32'd1 : 32'd0; e.c = (a < b); end
            4'd11: e.r = (sa < sb) ? 32'd1 : 32'd0;
            4'd12: begin e.r = 32'($signed(b) >>> sh); e.c = (sh != 0) ? b[sh-1] : 1'b0; end
            4'd13: begin e.r = b >> sh; e.c = (sh != 0) ? b[sh-1] : 1'b0; end
            default: begin e.r = b << sh; e.c = (sh != 0) ? b[32-sh] : 1'b0; end
        endcase
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    // One clock of stimulus: check ready before the edge, result after it.
    task automatic step(input logic [1:0] v, input logic rr, output logic [1:0] granted);
        logic       pref;
        logic [1:0] g, er;
        logic       acc, sel, hs;
        logic [36:0] got;
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
`ifdef ALU_ARBITER_RR_EN
        pref = m_ptr;
`else
        pref = 1'b0;
`endif
        g   = (v == 2'b11) ? (pref ? 2'b10 : 2'b01) : v;
        er  = (!m_valid || rr) ? g : 2'b00;
        check("req_ready", 64'(req_ready), 64'(er));
        acc = |er;
        sel = er[1];
        hs  = m_valid && rr;
        if (acc) exp_q.push_back(sel ? model(1'b1, a1, b1, c1) : model(1'b0, a0, b0, c0));
        @(posedge clk);
        #1;
        if (hs) begin
            exp_q.delete(0);
            m_count++;
        end
        if (acc) begin
            m_valid = 1'b1;
`ifdef ALU_ARBITER_RR_EN
            m_ptr = ~sel;
`endif
        end else if (hs) begin
            m_valid = 1'b0;
        end
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("op_count", 64'(op_count), 64'(m_count));
        if (m_valid && exp_q.size() > 0) begin
            got = {rsp_id, rsp_r, rsp_zero, rsp_carry, rsp_negative, rsp_overflow};
            check("rsp", 64'(got), 64'(exp_q[0]));
        end
        granted = er;
    endtask

    initial begin
        logic [1:0]       gr;
        logic [1:0]       pv;
        logic [3:0]       rr_ids;
        logic [CNT_W-1:0] cnt_before;

        total = 0;
        bad = 0;
        m_valid = 1'b0;
        m_count = '0;
`ifdef ALU_ARBITER_RR_EN
        m_ptr = 1'b0;
        rr_ids = 4'b1010;
`else
        rr_ids = 4'b0000;
`endif
        rst_n = 1'b0;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; c0 = '0; c1 = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_r", 64'(rsp_r), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_flags", 64'({rsp_zero, rsp_carry, rsp_negative, rsp_overflow}), 64'(0));
        check("rst_count", 64'(op_count), 64'(0));
        rst_n = 1'b1;

        // Both ports valid for four cycles, consumer always ready.
        a0 = 32'd10; b0 = 32'd3; c0 = 4'b0000;
        a1 = 32'd10; b1 = 32'd3; c1 = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step(2'b11, 1'b1, gr);
            check("arb_id", 64'(rsp_id), 64'(rr_ids[i]));
        end
        step(2'b00, 1'b1, gr);

        // Signed overflow on ADD, then AND that must clear the stale flags.
        a0 = 32'h7FFF_FFFF; b0 = 32'h0000_0001; c0 = 4'b0010;
        step(2'b01, 1'b1, gr);
        check("add_r", 64'(rsp_r), 64'h8000_0000);
        check("add_flags", 64'({rsp_zero, rsp_carry, rsp_negative, rsp_overflow}), 64'(4'b0011));
        check("add_id", 64'(rsp_id), 64'(0));
        a0 = 32'hF0F0_F0F0; b0 = 32'h0F0F_0F0F; c0 = 4'b0100;
        step(2'b01, 1'b1, gr);
        check("and_r", 64'(rsp_r), 64'(0));
        check("and_flags", 64'({rsp_zero, rsp_carry, rsp_negative, rsp_overflow}), 64'(4'b1000));
        step(2'b00, 1'b1, gr);

        // Port 1 SUBU held under back-pressure with both ports requesting.
        a1 = 32'd1; b1 = 32'd2; c1 = 4'b0001;
        step(2'b10, 1'b1, gr);
        for (int i = 0; i < 3; i++) begin
            step(2'b11, 1'b0, gr);
            check("stall_r", 64'(rsp_r), 64'hFFFF_FFFF);
            check("stall_carry", 64'(rsp_carry), 64'(1));
            check("stall_ready", 64'(gr), 64'(0));
        end
        cnt_before = op_count;
        step(2'b00, 1'b1, gr);
        check("subu_count", 64'(op_count), 64'(cnt_before + CNT_W'(1)));

        // Mixed traffic; a waiting port keeps its operands until granted.
        pv = 2'b00;
        gr = 2'b00;
        for (int i = 0; i < 40; i++) begin
            logic [1:0] v;
            v = 2'($urandom_range(0, 3));
            if (pv[0] && !gr[0]) v[0] = 1'b1;
            else begin a0 = $urandom; b0 = $urandom; c0 = 4'($urandom_range(0, 15)); end
            if (pv[1] && !gr[1]) v[1] = 1'b1;
            else begin a1 = $urandom; b1 = $urandom; c1 = 4'($urandom_range(0, 15)); end
            pv = v;
            step(v, 1'($urandom_range(0, 3) != 0), gr);
        end
        step(2'b00, 1'b1, gr);

        // Reset while a result is held.
        a0 = 32'd5; b0 = 32'd6; c0 = 4'b0000;
        step(2'b01, 1'b0, gr);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(rsp_valid), 64'(0));
        check("midrst_count", 64'(op_count), 64'(0));
        check("midrst_r", 64'(rsp_r), 64'(0));
        exp_q.delete();
        m_valid = 1'b0;
        m_count = '0;
`ifdef ALU_ARBITER_RR_EN
        m_ptr = 1'b0;
`endif
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a1 = 32'd4; b1 = 32'h0000_0080; c1 = 4'b1101;
        step(2'b10, 1'b1, gr);
        check("post_rst_r", 64'(rsp_r), 64'h0000_0008);
        check("post_rst_id", 64'(rsp_id), 64'(1));
        step(2'b00, 1'b1, gr);
        check("post_rst_count", 64'(op_count), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
